imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Boot-time writer for the core's word-indexed instruction memory; the core's fetch path is the read end.
//  Accepts a byte stream (valid/ready) framed as: LEN_LO, LEN_HI, LEN*4 data bytes, CSUM.
//  Assembles 32-bit little-endian words and drives the I-mem write port.
//  Holds the core in reset (core_hold) until a frame completes cleanly.
// PARAMETERS
//  DEPTH           64       instruction memory depth in words; LEN > DEPTH is an error
//  ADDR_W          6        width of imem_waddr (clog2(DEPTH))
//  TIMEOUT_CYCLES  1000000  max idle cycles between accepted bytes mid-frame; 0 disables
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high
//  load_start   in   1       1-cycle pulse: begin a frame (honoured only in IDLE/DONE/ERR)
//  byte_valid   in   1       source has a byte on byte_data
//  byte_data    in   8       stream byte
//  byte_ready   out  1       loader accepts byte this cycle
//  imem_we      out  1       I-mem write strobe, 1 cycle per word
//  imem_waddr   out  ADDR_W  I-mem word index
//  imem_wdata   out  32      I-mem write word
//  core_hold    out  1       hold core PC/regfile in reset
//  done         out  1       frame loaded, checksum good
//  error        out  1       frame aborted
//  error_code   out  2       01 overflow, 10 checksum, 11 timeout, 00 none
//  words_loaded out  ADDR_W+1  words written in current/last frame
// BEHAVIOUR
//  Reset (async): state IDLE; byte_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_hold=1,
//   done=0, error=0, error_code=0, words_loaded=0; byte counter, LEN, XOR accumulator cleared.
//  Byte accepted iff byte_valid && byte_ready on a rising edge. One byte per cycle max.
//  byte_ready=1 in LEN0, LEN1, DATA, CSUM; 0 in IDLE, DONE, ERR (registered, state-decoded).
//  core_hold=0 only in DONE; 1 in every other state.
//  States/transitions:
//   IDLE/DONE/ERR --load_start--> LEN0; clears done, error, error_code, words_loaded, XOR, counters.
//   LEN0 --accept--> LEN1 (LEN[7:0]=byte).  LEN1 --accept--> LEN[15:8]=byte, then:
//     LEN>DEPTH -> ERR code 01; LEN==0 -> CSUM; else DATA.
//   DATA: byte k of word goes to bits [8k+7:8k] (k=0..3). On accept of k=3: next cycle imem_we=1,
//     imem_wdata=assembled word, imem_waddr=word index (0,1,2,...), words_loaded+=1.
//     After word LEN-1 is accepted -> CSUM.
//   CSUM --accept--> byte == XOR of all prior frame bytes (LEN bytes + data) ? DONE : ERR code 10.
//  imem_we is 1 for exactly one cycle per word; never asserted outside DATA-completion; never
//   asserted for index >= DEPTH. imem_waddr/imem_wdata hold last written values otherwise.
//  Timeout: in LEN0..CSUM, counter counts cycles without an accepted byte, cleared on accept;
//   reaching TIMEOUT_CYCLES -> ERR code 11. Counter cleared on entering LEN0.
//  load_start while in LEN0..CSUM is ignored. load_start coincident with an accept in DONE/ERR:
//   restart wins (no accept occurs, byte_ready=0 there).
//  ERR: done=0, error=1, core_hold=1; words already written stay in memory.
//  Reset asserted mid-frame: immediate return to reset values; partially written words remain.
// TESTING
//  1. load_start; bytes 02 00 93 00 50 00 13 01 10 00 C3 -> writes [0]=00500093, [1]=00100113;
//     done=1, core_hold=0, words_loaded=2, error=0.
//  2. Same frame, last byte C4 -> both words written, then error=1, error_code=10, core_hold=1.
//  3. Length bytes 41 00 (65 > DEPTH=64) -> ERR code 01 one cycle after LEN_HI; no imem_we ever.
//  4. LEN=0: bytes 00 00 00 -> done=1, no imem_we; LEN=1 with byte_valid gaps of 3 cycles
//     between bytes -> single write correct, done=1.
//  5. TIMEOUT_CYCLES=16: send 02 00 93 then stall -> error_code=11 after 16 idle cycles;
//     load_start then good frame -> done=1, error cleared.
//  6. Reset asserted after 5th byte of test 1 -> all outputs at reset values next cycle;
//     load_start during DATA ignored (no counter clear).

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream (LEN_LO, LEN_HI, LEN*4 data, XOR csum) -> I-mem word writes; core held until good frame.
// Write lands the cycle after the 4th byte of a word; byte_ready is state-decoded (no dependence on byte_valid).
module imem_loader #(
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        error_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [15:0] DEPTH_L = 16'(DEPTH);

  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          k_q, k_d;
  logic [23:0]         asm_q, asm_d;
  logic [7:0]          xor_q, xor_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [ADDR_W:0]     wl_q, wl_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          code_q, code_d;
  logic                ready_q, hold_q, done_q, error_q;

  logic                accept;
  logic                active;
  logic [15:0]         len_full;

  assign active   = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept   = byte_valid && ready_q;
  assign len_full = {byte_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    k_d     = k_q;
    asm_d   = asm_q;
    xor_d   = xor_q;
    tmo_d   = tmo_q;
    wl_d    = wl_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    code_d  = code_q;

    if (active) begin
      tmo_d = accept ? '0 : tmo_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_start) begin
          state_d = S_LEN0;
          len_d   = '0;
          k_d     = '0;
          asm_d   = '0;
          xor_d   = '0;
          tmo_d   = '0;
          wl_d    = '0;
          code_d  = '0;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = byte_data;
          xor_d      = xor_q ^ byte_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d  = len_full;
          xor_d  = xor_q ^ byte_data;
          if (len_full > DEPTH_L) begin
            state_d = S_ERR;
            code_d  = ERR_OVF;
          end else if (len_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d = xor_q ^ byte_data;
          k_d   = k_q + 2'd1;
          unique case (k_q)
            2'd0: asm_d[7:0]   = byte_data;
            2'd1: asm_d[15:8]  = byte_data;
            2'd2: asm_d[23:16] = byte_data;
            default: begin
              we_d    = 1'b1;
              waddr_d = wl_q[ADDR_W-1:0];
              wdata_d = {byte_data, asm_q};
              wl_d    = wl_q + 1'b1;
              if (16'(wl_q) + 16'd1 == len_q) begin
                state_d = S_CSUM;
              end
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (byte_data == xor_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            code_d  = ERR_CSUM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Idle stall mid-frame: the TIMEOUT_CYCLES-th consecutive idle cycle aborts.
    if (TIMEOUT_CYCLES != 0 && active && !accept && tmo_q == TMO_LAST) begin
      state_d = S_ERR;
      code_d  = ERR_TMO;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      k_q     <= '0;
      asm_q   <= '0;
      xor_q   <= '0;
      tmo_q   <= '0;
      wl_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      code_q  <= '0;
      ready_q <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      k_q     <= k_d;
      asm_q   <= asm_d;
      xor_q   <= xor_d;
      tmo_q   <= tmo_d;
      wl_q    <= wl_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      code_q  <= code_d;
      ready_q <= (state_d == S_LEN0) || (state_d == S_LEN1) ||
                 (state_d == S_DATA) || (state_d == S_CSUM);
      hold_q  <= (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
      error_q <= (state_d == S_ERR);
    end
  end

  assign byte_ready   = ready_q;
  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign core_hold    = hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign error_code   = code_q;
  assign words_loaded = wl_q;

endmodule
